sobolrng_sched: RTL and testbench

Round-robin scheduler that shares one `sobolrng` instance between `NREQ` stochastic-bitstream requesters. It grants the RNG to one requester at a time for a fixed burst of `BURST` samples. During the burst it drives the RNG enable and forwards each Sobol sample to the granted requester with valid/last qualifiers. It sits between the `sobolrng` output and the comparator-based bitstream generators of each unary compute lane.

---
 rtl/sobolrng_sched.sv | 132 +++++++++++++
 tb/tb_sobolrng_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sobolrng_sched.sv
// sobolrng_sched: round-robin scheduler that shares one sobolrng between
// NREQ stochastic-bitstream requesters. Each grant lasts for a fixed burst
// of BURST samples. During the burst the RNG enable is driven and each
// Sobol sample is forwarded with valid/last qualifiers.
//
// Optional feature macro: SOBOLRNG_SCHED_RESTART_EN
//   defined   -> a CLR cycle precedes every burst and pulses oRngClr, so
//                every lane sees the Sobol sequence from index 0.
//   undefined -> no CLR state, oRngClr tied 0, and back-to-back bursts
//                have no gap.
module sobolrng_sched #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int BURST    = 256
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [NREQ-1:0]     iReq,
  input  logic                iHold,
  input  logic [BITWIDTH-1:0] iSobolSeq,
  output logic                oRngEn,
  output logic                oRngClr,
  output logic [NREQ-1:0]     oGnt,
  output logic                oValid,
  output logic                oLast,
  output logic [BITWIDTH-1:0] oData
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN} state_t;

`ifdef SOBOLRNG_SCHED_RESTART_EN
  localparam state_t GRANT_ST = CLR;
`else
  localparam state_t GRANT_ST = RUN;
`endif

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [LW-1:0]   last_q;
  logic [NREQ-1:0] gnt_q;

  logic [LW-1:0]   win_d;
  logic [NREQ-1:0] gnt_d;
  logic            found_d;
  logic            any_req;

  assign any_req = |iReq;

  // Round-robin winner: lowest requester above last_q, else wrap to the
  // lowest requester at or below last_q (the just-served one comes last).
  always_comb begin
    win_d   = last_q;
    found_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_d && iReq[i] && (i > int'(last_q))) begin
        found_d = 1'b1;
        win_d   = LW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_d && iReq[i] && (i <= int'(last_q))) begin
        found_d = 1'b1;
        win_d   = LW'(i);
      end
    end
    gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win_d;
  end

  // Burst FSM: grant, optional RNG clear, then BURST accepted samples.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LW'(NREQ - 1);
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= gnt_d;
            last_q  <= win_d;
            cnt_q   <= '0;
            state_q <= GRANT_ST;
          end
        end
        CLR: begin
          state_q <= RUN;
        end
        RUN: begin
          if (!iHold) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (any_req) begin
                gnt_q   <= gnt_d;
                last_q  <= win_d;
                state_q <= GRANT_ST;
              end else begin
                gnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Sample qualifiers are decoded from registered state; iHold gates them
  // in the same cycle so the RNG never advances on an unconsumed sample.
  assign oValid = (state_q == RUN) && !iHold;
  assign oRngEn = oValid;
  assign oLast  = oValid && (cnt_q == CNT_LAST);
  assign oGnt   = gnt_q;
  assign oData  = iSobolSeq;

`ifdef SOBOLRNG_SCHED_RESTART_EN
  assign oRngClr = (state_q == CLR);
`else
  assign oRngClr = 1'b0;
`endif

endmodule

// File: tb/tb_sobolrng_sched.sv
// Directed bench for sobolrng_sched (default build, BURST=8, NREQ=4).
// A stand-in RNG advances on oRngEn; its value for index k is k*29+3.
module tb_sobolrng_sched;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int BL = 8;

  logic          iClk;
  logic          iRst;
  logic [NR-1:0] iReq;
  logic          iHold;
  logic [BW-1:0] iSobolSeq;
  logic          oRngEn;
  logic          oRngClr;
  logic [NR-1:0] oGnt;
  logic          oValid;
  logic          oLast;
  logic [BW-1:0] oData;

  int errors = 0;
  int checks = 0;
  int rk     = 0;   // expected RNG index, tracked by the stimulus
  logic [BW-1:0] rng_idx;

  sobolrng_sched #(.BITWIDTH(BW), .NREQ(NR), .BURST(BL)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iHold(iHold),
    .iSobolSeq(iSobolSeq), .oRngEn(oRngEn), .oRngClr(oRngClr),
    .oGnt(oGnt), .oValid(oValid), .oLast(oLast), .oData(oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Stand-in RNG
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)         rng_idx <= '0;
    else if (oRngClr) rng_idx <= '0;
    else if (oRngEn)  rng_idx <= rng_idx + 8'd1;
  end
  assign iSobolSeq = 8'(rng_idx * 8'd29 + 8'd3);

  function automatic logic [BW-1:0] rng_val(input int k);
    return 8'(k * 29 + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [NR-1:0] g,
                            input logic v, input logic l);
    #1;
    chk({tag, ".gnt"},   32'(oGnt),    32'(g));
    chk({tag, ".valid"}, 32'(oValid),  32'(v));
    chk({tag, ".rngen"}, 32'(oRngEn),  32'(v));
    chk({tag, ".last"},  32'(oLast),   32'(l));
    chk({tag, ".clr"},   32'(oRngClr), 32'(0));
    if (v) begin
      chk({tag, ".data"}, 32'(oData), 32'(rng_val(rk)));
      rk++;
    end
  endtask

  initial begin
    logic [NR-1:0] rr_seq [4];
    logic [NR-1:0] fair_seq [3];
    rr_seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    fair_seq = '{4'b0001, 4'b0100, 4'b0001};

    iRst = 1'b1; iReq = '0; iHold = 1'b0;
    tick(); tick();
    expect_out("reset", 4'b0000, 1'b0, 1'b0);
    iRst = 1'b0;
    tick();
    expect_out("idle0", 4'b0000, 1'b0, 1'b0);

    // Single burst from requester 0, one-cycle request pulse
    iReq = 4'b0001;
    tick();
    iReq = 4'b0000;
    for (int k = 0; k < BL; k++) begin
      expect_out("single", 4'b0001, 1'b1, k == BL - 1);
      tick();
    end
    expect_out("single_idle", 4'b0000, 1'b0, 1'b0);

    // Requester 1 starts, then asynchronous reset at counter=5
    iReq = 4'b0010;
    tick();
    iReq = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      expect_out("pre_rst", 4'b0010, 1'b1, 1'b0);
      tick();
    end
    iRst = 1'b1;
    expect_out("mid_rst", 4'b0000, 1'b0, 1'b0);
    rk = 0;
    tick();
    iRst = 1'b0;
    tick();
    expect_out("post_rst", 4'b0000, 1'b0, 1'b0);

    // Round robin with 0111 held: 0,1,2,0 back-to-back; release in 4th burst
    iReq = 4'b0111;
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < BL; k++) begin
        if (b == 3 && k == 0) iReq = 4'b0000;
        expect_out("rr", rr_seq[b], 1'b1, k == BL - 1);
        tick();
      end
    end
    expect_out("rr_idle", 4'b0000, 1'b0, 1'b0);

    // Fairness: req0 held, req2 raised during burst 0 -> 0,2,0
    iReq = 4'b0001;
    tick();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < BL; k++) begin
        if (b == 0 && k == 2) iReq = 4'b0101;
        if (b == 2 && k == 0) iReq = 4'b0000;
        expect_out("fair", fair_seq[b], 1'b1, k == BL - 1);
        tick();
      end
    end
    expect_out("fair_idle", 4'b0000, 1'b0, 1'b0);

    // Hold for 3 cycles at sample 4 of a requester-3 burst
    iReq = 4'b1000;
    tick();
    iReq = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      expect_out("hold_pre", 4'b1000, 1'b1, 1'b0);
      tick();
    end
    iHold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      expect_out("hold", 4'b1000, 1'b0, 1'b0);
      tick();
    end
    iHold = 1'b0;
    for (int k = 4; k < BL; k++) begin
      expect_out("hold_post", 4'b1000, 1'b1, k == BL - 1);
      tick();
    end
    expect_out("hold_idle", 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
